mem_access_unit: RTL

- Sequential MEM-stage load/store engine for the MIPS pipeline; successor to the purely combinational MEM control decode.
- Takes the decoded MEM-stage request (read/write, access size, signedness, address, store data) and checks alignment.
- Drives a variable-latency data-memory bus with a req/ack handshake, generates byte enables and store-lane replication, and returns the extracted, sign- or zero-extended load data.
- Stalls the pipeline while an access is outstanding; reports address errors and bus timeouts to CP0.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage load/store engine.
// Helpers work on a 64-bit lane view; callers truncate to their bus width.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } acc_size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUS   = 2'b01,
    ST_DONE  = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  typedef struct packed {
    logic      is_ld;
    acc_size_t size;
    logic      uns;
  } req_meta_t;

  function automatic logic [7:0] be_gen(input acc_size_t size, input logic [2:0] off);
    case (size)
      SZ_B:    be_gen = 8'h01 << off;
      SZ_H:    be_gen = 8'h03 << off;
      SZ_W:    be_gen = 8'h0F << off;
      default: be_gen = 8'hFF;
    endcase
  endfunction

  // raw is already shifted so the addressed byte sits in bits [7:0]
  function automatic logic [63:0] ld_extend(input acc_size_t size, input logic uns,
                                            input logic [63:0] raw);
    case (size)
      SZ_B:    ld_extend = {{56{raw[7]  & ~uns}}, raw[7:0]};
      SZ_H:    ld_extend = {{48{raw[15] & ~uns}}, raw[15:0]};
      SZ_W:    ld_extend = {{32{raw[31] & ~uns}}, raw[31:0]};
      default: ld_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane alignment: byte enables, store replication, load extract/extend, misalign flag.
// Purely combinational, zero latency; no flow control.
// Used once on the store (request) path and once on the load (response) path.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                    size,
  input  logic [$clog2(DATA_W/8)-1:0]   off,
  input  logic                          uns,
  input  logic [DATA_W-1:0]             wr_src,
  input  logic [DATA_W-1:0]             rd_raw,
  output logic [DATA_W/8-1:0]           be,
  output logic [DATA_W-1:0]             wr_rep,
  output logic [DATA_W-1:0]             rd_ext,
  output logic                          misalign
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  acc_size_t   sz;
  logic [63:0] wr64;
  logic [63:0] rd_shift;

  assign sz       = acc_size_t'(size);
  assign rd_shift = 64'(rd_raw) >> {off, 3'b000};
  assign be       = NB'(be_gen(sz, 3'(off)));
  assign rd_ext   = DATA_W'(ld_extend(sz, uns, rd_shift));
  assign wr_rep   = DATA_W'(wr64);

  always_comb begin
    wr64 = 64'(wr_src);
    case (sz)
      SZ_B:    wr64 = {8{wr_src[7:0]}};
      SZ_H:    wr64 = {4{wr_src[15:0]}};
      SZ_W:    wr64 = {2{wr_src[31:0]}};
      default: wr64 = 64'(wr_src);
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    case (sz)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = off[0];
      SZ_W:    misalign = (off[1:0] != 2'b00);
      default: misalign = (DATA_W == 32) ? 1'b1 : (off != OFF_W'(0));
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: alignment check, req/ack data bus, load extension.
// Min 3 cycles per access (capture, bus with ack, done); bus wait bounded by MAX_WAIT.
// Stalls the pipeline while the bus is owed an ack; a flushed access drains unstalled.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            acc_size,
  input  logic                  ld_unsigned,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     st_data,
  input  logic                  flush,
  output logic                  stall,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  ld_valid,
  output logic                  adel,
  output logic                  ades,
  output logic                  bus_err,
  output logic [ADDR_W-1:0]     bad_vaddr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W/8-1:0]   dmem_be,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_t              state_q;
  req_meta_t           meta_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic                we_q;
  logic [NB-1:0]       be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   ld_data_q;

  logic [NB-1:0]       st_be;
  logic [DATA_W-1:0]   st_wdata;
  logic                st_misalign;
  logic [DATA_W-1:0]   st_unused_ld;
  logic [DATA_W-1:0]   ld_ext;
  logic [NB-1:0]       ld_unused_be;
  logic [DATA_W-1:0]   ld_unused_wdata;
  logic                ld_unused_mis;

  logic req_act, accept, addr_err, on_bus, timeout;

  mem_lane_align #(.DATA_W(DATA_W)) u_st_align (
    .size     (acc_size),
    .off      (addr[OFF_W-1:0]),
    .uns      (ld_unsigned),
    .wr_src   (st_data),
    .rd_raw   (dmem_rdata),
    .be       (st_be),
    .wr_rep   (st_wdata),
    .rd_ext   (st_unused_ld),
    .misalign (st_misalign)
  );

  mem_lane_align #(.DATA_W(DATA_W)) u_ld_align (
    .size     (meta_q.size),
    .off      (addr_q[OFF_W-1:0]),
    .uns      (meta_q.uns),
    .wr_src   (wdata_q),
    .rd_raw   (dmem_rdata),
    .be       (ld_unused_be),
    .wr_rep   (ld_unused_wdata),
    .rd_ext   (ld_ext),
    .misalign (ld_unused_mis)
  );

  // reset gates the request so every output is quiet while rst_n is low
  assign req_act  = rst_n & op_valid & (mem_read | mem_write) & ~flush;
  assign accept   = (state_q == ST_IDLE) & req_act & ~st_misalign;
  assign addr_err = (state_q == ST_IDLE) & req_act & st_misalign;
  assign on_bus   = (state_q == ST_BUS) | (state_q == ST_DRAIN);
  assign timeout  = on_bus & ~dmem_ack & (cnt_q == CNT_W'(MAX_WAIT - 1));

  assign stall      = accept | ((state_q == ST_BUS) & ~flush);
  assign adel       = addr_err & mem_read;
  assign ades       = addr_err & ~mem_read;
  assign ld_valid   = (state_q == ST_DONE) & meta_q.is_ld & ~err_q & ~flush;
  assign bus_err    = (state_q == ST_DONE) & err_q & ~flush;
  assign bad_vaddr  = addr_err ? addr : (bus_err ? addr_q : '0);
  assign ld_data    = ld_data_q;
  assign dmem_req   = on_bus;
  assign dmem_we    = we_q & on_bus;
  assign dmem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      meta_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      ld_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            meta_q  <= '{is_ld: mem_read, size: acc_size_t'(acc_size), uns: ld_unsigned};
            addr_q  <= addr;
            we_q    <= ~mem_read;
            be_q    <= st_be;
            wdata_q <= st_wdata;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= ST_BUS;
          end
        end
        ST_BUS: begin
          // a flushed access that still completes this cycle needs no drain
          if (dmem_ack) begin
            ld_data_q <= ld_ext;
            state_q   <= flush ? ST_IDLE : ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (timeout) begin
              err_q   <= 1'b1;
              state_q <= flush ? ST_IDLE : ST_DONE;
            end else if (flush) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (dmem_ack || timeout) state_q <= ST_IDLE;
          else                     cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
